similarity_argmax: RTL and testbench
====================================

SIMILARITY_ARGMAX -- requirements
Module: similarity_argmax

Interface
REQ-001 SHALL have parameter N, default 2048, hypervector width whose similarity scores are ranked.
REQ-002 SHALL have parameter AM_ADDR_WIDTH, default 13, associative-memory row address width.
REQ-003 SHALL have localparam SCORE_W = $clog2(N), score width matching the upstream bit counter.
REQ-004 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_i  input  1  one-cycle pulse opening a new search.
REQ-007 SHALL have port in_valid_i  input  1  candidate score/address valid this cycle.
REQ-008 SHALL have port score_i  input  SCORE_W  candidate similarity score (unsigned).
REQ-009 SHALL have port addr_i  input  AM_ADDR_WIDTH  AM row address of the candidate.
REQ-010 SHALL have port last_i  input  1  qualifies in_valid_i; marks final candidate of the search.
REQ-011 SHALL have port threshold_i  input  SCORE_W  minimum score for a valid match; sampled at result time.
REQ-012 SHALL have port out_ready_i  input  1  consumer accepts result.
REQ-013 SHALL have port busy_o  output  1  high in SEARCH state.
REQ-014 SHALL have port result_valid_o  output  1  result available, held until accepted.
REQ-015 SHALL have port best_addr_o  output  AM_ADDR_WIDTH  address of winning candidate.
REQ-016 SHALL have port best_score_o  output  SCORE_W  winning score.
REQ-017 SHALL have port margin_o  output  SCORE_W  best score minus second-best score.
REQ-018 SHALL have port no_match_o  output  1  best_score_o < threshold_i; valid only with result_valid_o.
REQ-019 SHALL have port cand_count_o  output  AM_ADDR_WIDTH+1  candidates accepted in the current/last search, saturating at all-ones.

Function
REQ-020 SHALL implement states IDLE, SEARCH, DONE; IDLE->SEARCH on start_i; SEARCH->DONE on accepted candidate with last_i=1; DONE->IDLE when result_valid_o && out_ready_i.
REQ-021 SHALL accept a candidate only when state==SEARCH and in_valid_i=1; in_valid_i in IDLE/DONE ignored; start_i-cycle candidate ignored.
REQ-022 SHALL on start_i (IDLE or SEARCH) clear best score, second score, best address, cand_count_o to 0 and enter SEARCH next cycle; start_i in SEARCH restarts search, discarding prior candidates.
REQ-023 SHALL ignore start_i in DONE; result remains held.
REQ-024 SHALL on first accepted candidate of a search load best=score_i, best_addr=addr_i, second=0.
REQ-025 SHALL on later candidates: score_i > best -> second=best, best=score_i, best_addr=addr_i; else score_i > second -> second=score_i; else no change.
REQ-026 SHALL break ties in favour of the earliest accepted candidate (equal score never replaces best; sets margin to 0).
REQ-027 SHALL compute margin_o = best - second, unsigned, never negative by construction.
REQ-028 SHALL increment cand_count_o per accepted candidate, saturating at 2^(AM_ADDR_WIDTH+1)-1.
REQ-029 SHALL assert result_valid_o the cycle after the last_i candidate is accepted (latency 1) and hold it and all result outputs stable until out_ready_i.
REQ-030 SHALL deassert result_valid_o the cycle after the handshake; result outputs retain values in IDLE.
REQ-031 SHALL compute no_match_o combinationally from registered best score vs threshold_i.
REQ-032 SHALL keep busy_o registered, high exactly while in SEARCH.

Reset
REQ-033 SHALL on rst_ni=0 asynchronously enter IDLE and drive all outputs and internal registers to 0; reset mid-search discards the search with no result.

Verification
REQ-034 SHALL cover: start, scores 10@0x5,40@0x9,25@0x2(last), threshold 20 -> next cycle result_valid=1, addr 0x9, score 40, margin 15, count 3, no_match 0.
REQ-035 SHALL cover: tie, 30@0x1,30@0x4(last) -> addr 0x1, margin 0.
REQ-036 SHALL cover: single candidate 7@0x3 last, threshold 8 -> score 7, margin 7, no_match 1.
REQ-037 SHALL cover: out_ready_i low 5 cycles then high -> outputs stable 5 cycles, result_valid drops cycle after handshake; start_i during hold ignored.
REQ-038 SHALL cover: start_i mid-search after 50@0x2, then 12@0x6 last -> addr 0x6, count 1.
REQ-039 SHALL cover: rst_ni pulsed mid-search -> IDLE, all outputs 0, no result_valid.

Source files
------------

// File: rtl/similarity_argmax.sv
// ----------------------------------------------------------------------------
// similarity_argmax
//   Streams candidate (score, address) pairs from an associative-memory scan.
//   It tracks the best and second-best scores and returns the winning address,
//   the winning score, the margin over the runner-up and a no-match flag.
//
// Ports
//   clk_i, rst_ni     clock (rising edge), asynchronous active-low reset
//   start_i           opens a new search; in SEARCH it restarts the search
//   in_valid_i        candidate present (only accepted in SEARCH)
//   score_i, addr_i   candidate similarity score and AM row address
//   last_i            marks the final candidate of the search
//   threshold_i       minimum score for a match, compared live at result time
//   out_ready_i       consumer accepts the held result
//   busy_o            high while searching
//   result_valid_o    result held until out_ready_i
//   best_addr_o, best_score_o, margin_o, no_match_o   result fields
//   cand_count_o      accepted candidates in this search (saturating)
// ----------------------------------------------------------------------------
module similarity_argmax #(
   parameter  int N             = 2048,
   parameter  int AM_ADDR_WIDTH = 13,
   localparam int SCORE_W       = $clog2(N)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic                     in_valid_i,
   input  logic [SCORE_W-1:0]       score_i,
   input  logic [AM_ADDR_WIDTH-1:0] addr_i,
   input  logic                     last_i,
   input  logic [SCORE_W-1:0]       threshold_i,
   input  logic                     out_ready_i,
   output logic                     busy_o,
   output logic                     result_valid_o,
   output logic [AM_ADDR_WIDTH-1:0] best_addr_o,
   output logic [SCORE_W-1:0]       best_score_o,
   output logic [SCORE_W-1:0]       margin_o,
   output logic                     no_match_o,
   output logic [AM_ADDR_WIDTH:0]   cand_count_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd2} state_e;

   localparam logic [AM_ADDR_WIDTH:0] CNT_ONE = {{AM_ADDR_WIDTH{1'b0}}, 1'b1};

   state_e                     state_q, state_d;
   logic [SCORE_W-1:0]         best_q, best_d;
   logic [SCORE_W-1:0]         second_q, second_d;
   logic [AM_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [AM_ADDR_WIDTH:0]     cnt_q, cnt_d;
   logic                       busy_q, busy_d;
   logic                       valid_q, valid_d;

   always_comb begin
      state_d  = state_q;
      best_d   = best_q;
      second_d = second_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               best_d   = '0;
               second_d = '0;
               addr_d   = '0;
               cnt_d    = '0;
               state_d  = SEARCH;
            end
         end
         SEARCH: begin
            if (start_i) begin
               // restart: a candidate in the same cycle belongs to no search
               best_d   = '0;
               second_d = '0;
               addr_d   = '0;
               cnt_d    = '0;
            end else if (in_valid_i) begin
               // count never wraps back to zero, so zero means "first candidate"
               if (cnt_q == '0) begin
                  best_d   = score_i;
                  addr_d   = addr_i;
                  second_d = '0;
               end else if (score_i > best_q) begin
                  second_d = best_q;
                  best_d   = score_i;
                  addr_d   = addr_i;
               end else if (score_i > second_q) begin
                  // equal-to-best lands here: earliest keeps the win, margin 0
                  second_d = score_i;
               end
               if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
               if (last_i) state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d  = (state_d == SEARCH);
      valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         best_q   <= '0;
         second_q <= '0;
         addr_q   <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         best_q   <= best_d;
         second_q <= second_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
      end
   end

   assign busy_o         = busy_q;
   assign result_valid_o = valid_q;
   assign best_addr_o    = addr_q;
   assign best_score_o   = best_q;
   assign margin_o       = best_q - second_q;  // second <= best always holds
   assign cand_count_o   = cnt_q;
   // gated so the flag reads 0 outside a held result (including after reset)
   assign no_match_o     = valid_q & (best_q < threshold_i);

endmodule

// File: tb/tb_similarity_argmax.sv
// ----------------------------------------------------------------------------
// tb_similarity_argmax
//   Directed bench for similarity_argmax. A reference model keeps the list of
//   candidates accepted in the current search and derives best/second/count
//   from that list; a compare process checks every DUT output each cycle.
//   Literal checks pin the model on the hand-worked scenarios.
// ----------------------------------------------------------------------------
module tb_similarity_argmax;

   localparam int N   = 2048;
   localparam int AW  = 4;
   localparam int SW  = $clog2(N);
   localparam int SAT = (1 << (AW + 1)) - 1;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          start_i = 1'b0;
   logic          in_valid_i = 1'b0;
   logic [SW-1:0] score_i = '0;
   logic [AW-1:0] addr_i = '0;
   logic          last_i = 1'b0;
   logic [SW-1:0] threshold_i = '0;
   logic          out_ready_i = 1'b0;
   logic          busy_o, result_valid_o, no_match_o;
   logic [AW-1:0] best_addr_o;
   logic [SW-1:0] best_score_o, margin_o;
   logic [AW:0]   cand_count_o;

   int n_cmp = 0;
   int n_bad = 0;

   similarity_argmax #(.N(N), .AM_ADDR_WIDTH(AW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .in_valid_i(in_valid_i),
      .score_i(score_i), .addr_i(addr_i), .last_i(last_i),
      .threshold_i(threshold_i), .out_ready_i(out_ready_i),
      .busy_o(busy_o), .result_valid_o(result_valid_o),
      .best_addr_o(best_addr_o), .best_score_o(best_score_o),
      .margin_o(margin_o), .no_match_o(no_match_o),
      .cand_count_o(cand_count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // phase: 0 idle, 1 searching, 2 result held
   int          m_phase = 0;
   int unsigned m_sc[$];
   int unsigned m_ad[$];

   task automatic model_result(output int unsigned b, output int unsigned a,
                               output int unsigned s, output int unsigned c);
      int bi;
      b = 0; a = 0; s = 0; bi = -1;
      foreach (m_sc[i]) if (bi < 0 || m_sc[i] > b) begin b = m_sc[i]; a = m_ad[i]; bi = i; end
      foreach (m_sc[i]) if (i != bi && m_sc[i] > s) s = m_sc[i];
      c = (m_sc.size() > SAT) ? SAT : m_sc.size();
   endtask

   initial forever begin
      int unsigned b, a, s, c;
      logic r, st, v, la, rd;
      @(posedge clk_i);
      r = rst_ni; st = start_i; v = in_valid_i; la = last_i; rd = out_ready_i;
      if (!r) begin
         m_phase = 0; m_sc.delete(); m_ad.delete();
      end else begin
         case (m_phase)
            0: if (st) begin m_sc.delete(); m_ad.delete(); m_phase = 1; end
            1: if (st) begin m_sc.delete(); m_ad.delete(); end
               else if (v) begin
                  m_sc.push_back(score_i); m_ad.push_back(addr_i);
                  if (la) m_phase = 2;
               end
            default: if (rd) m_phase = 0;
         endcase
      end
      #1;
      model_result(b, a, s, c);
      chk("busy",   busy_o,         m_phase == 1);
      chk("valid",  result_valid_o, m_phase == 2);
      chk("addr",   best_addr_o,    a);
      chk("score",  best_score_o,   b);
      chk("margin", margin_o,       b - s);
      chk("count",  cand_count_o,   c);
      chk("nomatch", no_match_o,    (m_phase == 2) && (b < threshold_i));
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic st, input logic v, input int sc, input int ad,
                        input logic la, input logic rd);
      @(negedge clk_i);
      start_i = st; in_valid_i = v; score_i = SW'(sc); addr_i = AW'(ad);
      last_i = la; out_ready_i = rd;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic wait_result();
      int k = 0;
      while (!result_valid_o && k < 20) begin @(negedge clk_i); k++; end
      chk("result_timeout", result_valid_o, 1);
   endtask

   task automatic handshake();
      drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk_i);
      chk("rst_busy", busy_o, 0);
      chk("rst_valid", result_valid_o, 0);
      chk("rst_count", cand_count_o, 0);
      rst_ni = 1'b1;
      idle(2);

      // basic search: 10@5, 40@9, 25@2 last, threshold 20
      threshold_i = 20;
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, 10, 5, 0, 0);
      drive(0, 1, 40, 9, 0, 0);
      drive(0, 1, 25, 2, 1, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("t1_valid", result_valid_o, 1);
      chk("t1_addr", best_addr_o, 9);
      chk("t1_score", best_score_o, 40);
      chk("t1_margin", margin_o, 15);
      chk("t1_count", cand_count_o, 3);
      chk("t1_nomatch", no_match_o, 0);
      handshake();
      chk("t1_drop", result_valid_o, 0);

      // tie: earliest wins, margin 0
      threshold_i = 0;
      drive(1, 1, 99, 7, 0, 0);          // candidate on start cycle is ignored
      drive(0, 1, 30, 1, 0, 0);
      drive(0, 1, 30, 4, 1, 0);
      wait_result();
      chk("t2_addr", best_addr_o, 1);
      chk("t2_margin", margin_o, 0);
      chk("t2_count", cand_count_o, 2);
      handshake();

      // single candidate below threshold
      threshold_i = 8;
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, 7, 3, 1, 0);
      wait_result();
      chk("t3_score", best_score_o, 7);
      chk("t3_margin", margin_o, 7);
      chk("t3_nomatch", no_match_o, 1);
      handshake();

      // held result: consumer stalls 5 cycles, start/valid ignored in DONE
      threshold_i = 20;
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, 5, 7, 0, 0);
      drive(0, 1, 60, 10, 0, 0);
      drive(0, 1, 33, 11, 1, 0);
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, 200, 2, 1, 0);
      drive(1, 1, 300, 3, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("t4_hold_valid", result_valid_o, 1);
      chk("t4_hold_addr", best_addr_o, 10);
      chk("t4_hold_score", best_score_o, 60);
      chk("t4_hold_margin", margin_o, 27);
      threshold_i = 61;
      #1 chk("t4_live_thresh", no_match_o, 1);
      drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0);
      chk("t4_drop", result_valid_o, 0);
      chk("t4_retain_addr", best_addr_o, 10);

      // restart mid-search
      threshold_i = 0;
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, 50, 2, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, 12, 6, 1, 0);
      wait_result();
      chk("t5_addr", best_addr_o, 6);
      chk("t5_count", cand_count_o, 1);
      chk("t5_score", best_score_o, 12);
      handshake();

      // reset mid-search
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, 20, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      rst_ni = 1'b0;
      #1;
      chk("t6_busy", busy_o, 0);
      chk("t6_score", best_score_o, 0);
      chk("t6_count", cand_count_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      idle(3);
      chk("t6_no_result", result_valid_o, 0);

      // counter saturation
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < SAT + 4; i++)
         drive(0, 1, int'($urandom_range(0, N - 1)), i % 16, i == SAT + 3, 0);
      wait_result();
      chk("t7_sat", cand_count_o, SAT);
      handshake();
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
